multicycle_cpu: RTL and testbench

MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

---
 rtl/multicycle_cpu.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_cpu.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - multicycle 4-register CPU with handshaked instruction and data memories
//
// Purpose : FETCH -> EXEC (-> MEM) -> FETCH processor. 16-bit instructions
//           op[15:12] rd[11:10] rs[9:8] imm[7:0]; HALT parks the core.
// Optional: define MULTICYCLE_CPU_STEP_EN to add the step input and a WAIT
//           state that gates each fetch after a retired instruction.
// Ports   : clk, reset (async, active-high)
//           imem_req/imem_addr/imem_ack/imem_data   instruction fetch
//           dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_rdata/dmem_ack  data
//           out_port/out_valid                       output register + pulse
//           carry_flag/zero_flag/negative_flag/halted/pc  status
//           step (only with MULTICYCLE_CPU_STEP_EN)  single-step enable
module multicycle_cpu #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
) (
`ifdef MULTICYCLE_CPU_STEP_EN
    input  logic              step,
`endif
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [7:0]        dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              negative_flag,
    output logic              halted,
    output logic [PC_W-1:0]   pc
);

    localparam logic [3:0] OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5, OP_XOR = 4'h6, OP_LD  = 4'h7, OP_ST  = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_JC  = 4'hB, OP_JN  = 4'hC;
    localparam logic [3:0] OP_OUT = 4'hD, OP_ADDI = 4'hE, OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
`ifdef MULTICYCLE_CPU_STEP_EN
        S_WAIT,
`endif
        S_HALTED
    } state_t;

    // Where a retired (non-HALT) instruction hands over to.
`ifdef MULTICYCLE_CPU_STEP_EN
    localparam state_t S_RETIRE = S_WAIT;
`else
    localparam state_t S_RETIRE = S_FETCH;
`endif

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [15:0]         ir_q;
    logic [DATA_W-1:0]   regs_q [4];
    logic                z_q, c_q, n_q;
    logic [DATA_W-1:0]   out_q;
    logic                out_valid_q;

    logic [3:0]          op;
    logic [1:0]          rd_idx, rs_idx;
    logic [7:0]          imm;
    logic [DATA_W-1:0]   imm_ext, rd_val, rs_val;
    logic [DATA_W:0]     alu_wide;
    logic                alu_we, taken, is_mem;

    assign op      = ir_q[15:12];
    assign rd_idx  = ir_q[11:10];
    assign rs_idx  = ir_q[9:8];
    assign imm     = ir_q[7:0];
    assign imm_ext = DATA_W'(imm);
    assign rd_val  = regs_q[rd_idx];
    assign rs_val  = regs_q[rs_idx];
    assign is_mem  = (op == OP_LD) || (op == OP_ST);

    // Bit DATA_W carries the add carry-out; for SUB the extended subtraction
    // sets it exactly when rd < rs (unsigned borrow); logic ops leave it 0.
    always_comb begin
        alu_wide = '0;
        alu_we   = 1'b0;
        case (op)
            OP_ADD:  begin alu_wide = {1'b0, rd_val} + {1'b0, rs_val};  alu_we = 1'b1; end
            OP_SUB:  begin alu_wide = {1'b0, rd_val} - {1'b0, rs_val};  alu_we = 1'b1; end
            OP_AND:  begin alu_wide = {1'b0, rd_val & rs_val};          alu_we = 1'b1; end
            OP_OR:   begin alu_wide = {1'b0, rd_val | rs_val};          alu_we = 1'b1; end
            OP_XOR:  begin alu_wide = {1'b0, rd_val ^ rs_val};          alu_we = 1'b1; end
            OP_ADDI: begin alu_wide = {1'b0, rd_val} + {1'b0, imm_ext}; alu_we = 1'b1; end
            default: ;
        endcase
    end

    // Jumps look at the flags as they stand; nothing here writes them.
    always_comb begin
        taken = 1'b0;
        case (op)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = z_q;
            OP_JC:   taken = c_q;
            OP_JN:   taken = n_q;
            default: ;
        endcase
        pc_d = taken ? imm[PC_W-1:0] : pc_q + PC_W'(1);
    end

    // Requests are gated by reset so an assertion drops them immediately,
    // even though the state register already reads FETCH during reset.
    always_comb begin
        state_d  = state_q;
        imem_req = (state_q == S_FETCH) && !reset;
        dmem_req = (state_q == S_MEM) && !reset;
        dmem_we  = (state_q == S_MEM) && !reset && (op == OP_ST);
        case (state_q)
            S_FETCH:  if (imem_ack) state_d = S_EXEC;
            S_EXEC: begin
                if (is_mem)              state_d = S_MEM;
                else if (op == OP_HALT)  state_d = S_HALTED;
                else                     state_d = S_RETIRE;
            end
            S_MEM:    if (dmem_ack) state_d = S_RETIRE;
`ifdef MULTICYCLE_CPU_STEP_EN
            S_WAIT:   if (step) state_d = S_FETCH;
`endif
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= '0;
            ir_q        <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            n_q         <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_FETCH: if (imem_ack) ir_q <= imem_data;
                S_EXEC: begin
                    pc_q <= pc_d;
                    if (alu_we) begin
                        regs_q[rd_idx] <= alu_wide[DATA_W-1:0];
                        z_q            <= (alu_wide[DATA_W-1:0] == '0);
                        c_q            <= alu_wide[DATA_W];
                        n_q            <= alu_wide[DATA_W-1];
                    end
                    if (op == OP_LDI) regs_q[rd_idx] <= imm_ext;
                    if (op == OP_OUT) begin
                        out_q       <= rd_val;
                        out_valid_q <= 1'b1;
                    end
                end
                S_MEM: if (dmem_ack && (op == OP_LD)) regs_q[rd_idx] <= dmem_rdata;
                default: ;
            endcase
        end
    end

    assign imem_addr     = pc_q;
    assign dmem_addr     = imm;
    assign dmem_wdata    = rd_val;
    assign out_port      = out_q;
    assign out_valid     = out_valid_q;
    assign carry_flag    = c_q;
    assign zero_flag     = z_q;
    assign negative_flag = n_q;
    assign halted        = (state_q == S_HALTED);
    assign pc            = pc_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb/tb_multicycle_cpu.sv - self-checking bench for multicycle_cpu
module tb_multicycle_cpu;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic [7:0]  imem_addr, dmem_addr, dmem_wdata, out_port, pc;
    logic [15:0] imem_data = 16'h0;
    logic [7:0]  dmem_rdata = 8'h0;
    logic        out_valid, carry_flag, zero_flag, negative_flag, halted;

    logic        i4_req, i4_ack, d4_req, d4_we, o4_valid, c4, z4, n4, h4;
    logic [3:0]  i4_addr, pc4;
    logic [7:0]  d4_addr, d4_wdata, o4_port;
    assign i4_ack = i4_req;

`ifdef MULTICYCLE_CPU_STEP_EN
    logic step = 1'b1;
    logic step4 = 1'b1;
`endif

    multicycle_cpu #(.DATA_W(8), .PC_W(8)) dut (
`ifdef MULTICYCLE_CPU_STEP_EN
        .step(step),
`endif
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .out_port(out_port), .out_valid(out_valid), .carry_flag(carry_flag), .zero_flag(zero_flag),
        .negative_flag(negative_flag), .halted(halted), .pc(pc)
    );

    // Small-PC instance fed an endless stream of NOPs.
    multicycle_cpu #(.DATA_W(8), .PC_W(4)) dut4 (
`ifdef MULTICYCLE_CPU_STEP_EN
        .step(step4),
`endif
        .clk(clk), .reset(reset),
        .imem_req(i4_req), .imem_addr(i4_addr), .imem_ack(i4_ack), .imem_data(16'h0000),
        .dmem_req(d4_req), .dmem_we(d4_we), .dmem_addr(d4_addr), .dmem_wdata(d4_wdata),
        .dmem_rdata(8'h00), .dmem_ack(1'b0),
        .out_port(o4_port), .out_valid(o4_valid), .carry_flag(c4), .zero_flag(z4),
        .negative_flag(n4), .halted(h4), .pc(pc4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int imm);
        return {4'(op), 2'(rd), 2'(rs), 8'(imm)};
    endfunction

    // ---------------- memory responders ----------------
    logic [15:0] imem [256];
    logic [7:0]  dmem [256];
    int idelay = 0, ddelay = 0, icnt = 0, dcnt = 0;
    logic iack_r = 1'b0, dack_r = 1'b0, force_dack = 1'b0;
    logic [7:0] ihold, dahold, dwhold;
    logic       wehold;
    logic [7:0] obs_q [$];
    logic [7:0] fetch_addrs [$];

    assign imem_ack = iack_r;
    assign dmem_ack = dack_r | force_dack;

    always @(negedge clk) begin
        if (imem_req) begin
            if (icnt == 0) ihold = imem_addr;
            else chk("imem_addr_stable", imem_addr, ihold);
            imem_data = imem[imem_addr];
            iack_r = (icnt == idelay);
            if (iack_r) fetch_addrs.push_back(imem_addr);
            icnt++;
        end else begin
            iack_r = 1'b0;
            icnt = 0;
        end
        if (dmem_req) begin
            if (dcnt == 0) begin
                dahold = dmem_addr; dwhold = dmem_wdata; wehold = dmem_we;
            end else begin
                chk("dmem_addr_stable", dmem_addr, dahold);
                chk("dmem_wdata_stable", dmem_wdata, dwhold);
                chk("dmem_we_stable", dmem_we, wehold);
            end
            dmem_rdata = dmem[dmem_addr];
            dack_r = (dcnt == ddelay);
            if (dack_r && dmem_we) dmem[dmem_addr] = dmem_wdata;
            dcnt++;
        end else begin
            dack_r = 1'b0;
            dcnt = 0;
        end
        if (out_valid) obs_q.push_back(out_port);
    end

    // ---------------- ISA-level reference model ----------------
    int         m_r [4];
    logic [7:0] mdmem [256];
    logic       mz, mc, mn;
    int         mout [$];
    int         mcyc;

    task automatic model_run();
        int p = 0;
        int steps = 0;
        for (int i = 0; i < 4; i++) m_r[i] = 0;
        mz = 0; mc = 0; mn = 0; mcyc = 0; mout.delete();
        while (steps < 5000) begin
            logic [15:0] w;
            int op, rd, rs, imm, a, b, res, nxt, cost;
            w = imem[p];
            op = int'(w[15:12]); rd = int'(w[11:10]); rs = int'(w[9:8]); imm = int'(w[7:0]);
            a = m_r[rd]; b = m_r[rs];
            nxt = (p + 1) % 256; cost = 2; steps++;
            if (op == 15) begin mcyc += 2; return; end
            case (op)
                1: m_r[rd] = imm;
                2, 3, 4, 5, 6, 14: begin
                    case (op)
                        2:  begin res = a + b;   mc = (res > 255); end
                        3:  begin res = a - b;   mc = (a < b); end
                        4:  begin res = a & b;   mc = 0; end
                        5:  begin res = a | b;   mc = 0; end
                        6:  begin res = a ^ b;   mc = 0; end
                        default: begin res = a + imm; mc = (res > 255); end
                    endcase
                    res = res & 255;
                    m_r[rd] = res; mz = (res == 0); mn = (res >= 128);
                end
                7:  begin m_r[rd] = int'(mdmem[imm]); cost = 3; end
                8:  begin mdmem[imm] = 8'(a); cost = 3; end
                9:  nxt = imm;
                10: if (mz) nxt = imm;
                11: if (mc) nxt = imm;
                12: if (mn) nxt = imm;
                13: mout.push_back(a);
                default: ;
            endcase
            mcyc += cost;
`ifdef MULTICYCLE_CPU_STEP_EN
            mcyc += 1;
`endif
            p = nxt;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = enc(15, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2 reset = 1'b1;
        obs_q.delete(); fetch_addrs.delete();
        @(posedge clk); #2 reset = 1'b0;
    endtask

    task automatic wait_halt(output int cyc);
        cyc = 0;
        while (!halted && cyc < 3000) begin
            @(posedge clk); #1 cyc++;
        end
        chk("halt_reached", halted, 1'b1);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"}, pc, 0);
        chk({tag, "_out_port"}, out_port, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_flags"}, {zero_flag, carry_flag, negative_flag}, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_reqs"}, {imem_req, dmem_req, dmem_we}, 0);
    endtask

    typedef struct {
        string             name;
        logic [7:0][15:0]  prog;
        logic [7:0]        exp_out;
        logic [2:0]        exp_zcn;
        int                exp_cyc;
        int                nret;
    } vec_t;

    function automatic logic [7:0][15:0] prog8(input logic [15:0] a, b, c, d, e,
                                               input logic [15:0] f = 16'hF000,
                                               input logic [15:0] g = 16'hF000,
                                               input logic [15:0] h = 16'hF000);
        logic [7:0][15:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f; r[6] = g; r[7] = h;
        return r;
    endfunction

    localparam int NV = 9;
    vec_t vecs [NV];

    initial begin
        int cyc;
        logic [15:0] HLT;
        HLT = enc(15, 0, 0, 0);

        vecs[0] = '{"req024_add", prog8(enc(1,0,0,5), enc(1,1,0,3), enc(2,0,1,0), enc(13,0,0,0), HLT), 8'h08, 3'b000, 10, 4};
        vecs[1] = '{"addi_wrap", prog8(enc(1,0,0,255), enc(14,0,0,1), enc(13,0,0,0), HLT, HLT), 8'h00, 3'b110, 8, 3};
        vecs[2] = '{"sub_borrow", prog8(enc(1,0,0,3), enc(1,1,0,5), enc(3,0,1,0), enc(13,0,0,0), HLT), 8'hFE, 3'b011, 10, 4};
        vecs[3] = '{"and", prog8(enc(1,2,0,8'hF0), enc(1,3,0,8'h3C), enc(4,2,3,0), enc(13,2,0,0), HLT), 8'h30, 3'b000, 10, 4};
        vecs[4] = '{"xor_self", prog8(enc(1,1,0,8'hAA), enc(6,1,1,0), enc(13,1,0,0), HLT, HLT), 8'h00, 3'b100, 8, 3};
        vecs[5] = '{"st_ld", prog8(enc(1,3,0,8'h77), enc(8,3,0,8'h10), enc(7,2,0,8'h10), enc(13,2,0,0), HLT), 8'h77, 3'b000, 12, 4};
        vecs[6] = '{"jmp", prog8(enc(1,0,0,1), enc(9,0,0,3), enc(1,0,0,9), enc(13,0,0,0), HLT), 8'h01, 3'b000, 8, 3};
        vecs[7] = '{"jc_flags_kept", prog8(enc(1,0,0,255), enc(14,0,0,1), enc(1,1,0,8'h42), enc(11,0,0,5),
                                           enc(1,1,0,8'h11), enc(13,1,0,0), HLT), 8'h42, 3'b110, 12, 5};
        vecs[8] = '{"or_neg", prog8(enc(1,0,0,8'h80), enc(1,1,0,1), enc(5,0,1,0), enc(13,0,0,0), HLT), 8'h81, 3'b001, 10, 4};

        clear_imem();
        for (int i = 0; i < 256; i++) dmem[i] = 8'h00;

        // Reset state.
        @(posedge clk); @(posedge clk); #1;
        chk_reset_outputs("reset_init");

        // Table-driven directed programs, zero-wait memories.
        for (int k = 0; k < NV; k++) begin
            int ecyc;
            clear_imem();
            for (int i = 0; i < 8; i++) imem[i] = vecs[k].prog[i];
            do_reset();
            wait_halt(cyc);
            ecyc = vecs[k].exp_cyc;
`ifdef MULTICYCLE_CPU_STEP_EN
            ecyc += vecs[k].nret;
`endif
            chk({vecs[k].name, "_out"}, out_port, vecs[k].exp_out);
            chk({vecs[k].name, "_zcn"}, {zero_flag, carry_flag, negative_flag}, vecs[k].exp_zcn);
            chk({vecs[k].name, "_cycles"}, cyc, ecyc);
            chk({vecs[k].name, "_pulses"}, obs_q.size(), 1);
        end

        // Taken JZ lands on 0x20.
        clear_imem();
        imem[0] = enc(1,0,0,255); imem[1] = enc(14,0,0,1); imem[2] = enc(10,0,0,8'h20);
        imem[8'h20] = enc(13,0,0,0);
        do_reset();
        wait_halt(cyc);
        chk("jz_target_fetch", fetch_addrs[3], 8'h20);
        chk("jz_out", out_port, 0);

        // Slow memories: ST then LD round-trip, stability checked by responder.
        clear_imem();
        for (int i = 0; i < 8; i++) imem[i] = vecs[5].prog[i];
        idelay = 3; ddelay = 2;
        do_reset();
        wait_halt(cyc);
        chk("slow_ld_value", out_port, 8'h77);
        chk("slow_st_mem", dmem[8'h10], 8'h77);
        chk("slow_pulses", obs_q.size(), 1);
        idelay = 0; ddelay = 0;

        // PC wrap with PC_W=4.
        begin
            int n = 0;
            do_reset();
            while (!(i4_req && i4_addr == 4'hF) && n < 200) begin @(negedge clk); n++; end
            chk("pc4_reached_15", i4_addr, 4'hF);
            @(negedge clk); n = 0;
            while (!i4_req && n < 20) begin @(negedge clk); n++; end
            chk("pc4_wrap_addr", i4_addr, 4'h0);
        end

        // Reset mid data handshake.
        begin
            int n = 0;
            clear_imem();
            imem[0] = enc(7,1,0,8'h10); imem[1] = enc(13,1,0,0);
            dmem[8'h10] = 8'h5A;
            ddelay = 5;
            do_reset();
            while (!dmem_req && n < 50) begin @(posedge clk); #1 n++; end
            chk("rst_mid_saw_dreq", dmem_req, 1);
            #1 reset = 1'b1;
            #1 chk_reset_outputs("rst_mid");
            @(negedge clk) force_dack = 1'b1;
            imem[0] = enc(13,1,0,0); imem[1] = HLT;
            obs_q.delete(); fetch_addrs.delete();
            @(posedge clk); #2 reset = 1'b0;
            wait_halt(cyc);
            chk("rst_mid_first_fetch", fetch_addrs[0], 0);
            chk("rst_mid_no_write", out_port, 0);
            force_dack = 1'b0;
            ddelay = 0;
        end

`ifdef MULTICYCLE_CPU_STEP_EN
        // Single-step gating.
        clear_imem();
        imem[0] = enc(1,0,0,1); imem[1] = enc(13,0,0,0); imem[2] = enc(1,0,0,2); imem[3] = enc(13,0,0,0);
        step = 1'b0;
        do_reset();
        repeat (20) @(posedge clk);
        #1 chk("step0_fetches", fetch_addrs.size(), 1);
        #1 step = 1'b1;
        @(posedge clk); #2 step = 1'b0;
        repeat (20) @(posedge clk);
        #1 chk("step1_fetches", fetch_addrs.size(), 2);
        chk("step1_outs", obs_q.size(), 1);
        chk("step1_out_val", out_port, 1);
        chk("step1_not_halted", halted, 0);
        step = 1'b1;
`endif

        // Randomized programs against the ISA model.
        for (int t = 0; t < 25; t++) begin
            int len;
            len = $urandom_range(8, 20);
            clear_imem();
            for (int i = 0; i < len; i++) begin
                int op, imm;
                op = $urandom_range(0, 14);
                imm = $urandom_range(0, 255);
                if (op == 7 || op == 8) imm = $urandom_range(0, 15);
                if (op >= 9 && op <= 12) begin
                    imm = i + 1 + $urandom_range(0, 2);
                    if (imm > len) imm = len;
                end
                imem[i] = enc(op, $urandom_range(0, 3), $urandom_range(0, 3), imm);
            end
            for (int i = 0; i < 256; i++) dmem[i] = 8'($urandom_range(0, 255));
            mdmem = dmem;
            model_run();
            if (t >= 15) begin idelay = $urandom_range(0, 2); ddelay = $urandom_range(0, 2); end
            do_reset();
            wait_halt(cyc);
            chk("rnd_out_count", obs_q.size(), mout.size());
            for (int i = 0; i < mout.size() && i < obs_q.size(); i++)
                chk("rnd_out_value", obs_q[i], mout[i]);
            chk("rnd_zcn", {zero_flag, carry_flag, negative_flag}, {mz, mc, mn});
            if (t < 15) chk("rnd_cycles", cyc, mcyc);
            for (int i = 0; i < 16; i++) chk("rnd_dmem", dmem[i], mdmem[i]);
            idelay = 0; ddelay = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
